// File: rtl/ip_sincos_cordic.sv
// ---------------------------------------------------------------------------
// ip_sincos_cordic
//   Iterative rotation-mode CORDIC sine/cosine generator. A phase word is
//   folded by quadrant, rotated through ITER micro-rotations (one per clock)
//   and the result is rounded, saturated and mapped back to the full circle.
//   Valid/ready handshakes on both sides; results hold under backpressure.
//
// Parameters
//   DEG_WD : phase width, full circle = 2^DEG_WD
//   OUT_WD : signed output width, 1.0 = 2^(OUT_WD-2)
//   ITER   : micro-rotations per result
//   GUARD  : extra LSBs carried in the x/y datapath
//
// Ports
//   clk     : clock
//   rst     : synchronous active-high reset
//   in_vld  : theta valid
//   in_rdy  : block can accept theta (combinational)
//   theta   : unsigned phase
//   out_vld : sin_val/cos_val valid (registered)
//   out_rdy : downstream accepts the result
//   sin_val : signed sine (registered)
//   cos_val : signed cosine (registered)
//   busy    : FSM not idle (registered)
// ---------------------------------------------------------------------------
module ip_sincos_cordic #(
  parameter int DEG_WD = 17,
  parameter int OUT_WD = 14,
  parameter int ITER   = 16,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DEG_WD-1:0] theta,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [OUT_WD-1:0] sin_val,
  output logic [OUT_WD-1:0] cos_val,
  output logic              busy
);

  localparam int W  = OUT_WD + GUARD;
  localparam int ZW = DEG_WD + 1;
  localparam int CW = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Start vector pre-scaled by 1/K so the rotated vector ends at unit length.
  localparam logic [63:0] X0_WIDE =
    ((64'd6072529350 << (W - 2)) + 64'd5000000000) / 64'd10000000000;
  localparam logic signed [W-1:0] X_INIT = W'(X0_WIDE);

  localparam logic signed [W:0] RND_HALF = (W+1)'(2 ** (GUARD - 1));
  localparam logic signed [W:0] POS_LIM  = (W+1)'(2 ** (OUT_WD - 2));
  localparam logic signed [W:0] NEG_LIM  = -POS_LIM;

  // atan(2^-i) in units of 2^32 per full turn.
  function automatic logic [31:0] atanTurn(input logic [CW-1:0] i);
    case (i)
      5'd0:    atanTurn = 32'h20000000;
      5'd1:    atanTurn = 32'h12E4051E;
      5'd2:    atanTurn = 32'h09FB385B;
      5'd3:    atanTurn = 32'h051111D4;
      5'd4:    atanTurn = 32'h028B0D43;
      5'd5:    atanTurn = 32'h0145D7E1;
      5'd6:    atanTurn = 32'h00A2F61E;
      5'd7:    atanTurn = 32'h00517C55;
      5'd8:    atanTurn = 32'h0028BE53;
      5'd9:    atanTurn = 32'h00145F2F;
      5'd10:   atanTurn = 32'h000A2F98;
      5'd11:   atanTurn = 32'h000517CC;
      5'd12:   atanTurn = 32'h00028BE6;
      5'd13:   atanTurn = 32'h000145F3;
      5'd14:   atanTurn = 32'h0000A2FA;
      5'd15:   atanTurn = 32'h0000517D;
      5'd16:   atanTurn = 32'h000028BE;
      5'd17:   atanTurn = 32'h0000145F;
      5'd18:   atanTurn = 32'h00000A30;
      5'd19:   atanTurn = 32'h00000518;
      5'd20:   atanTurn = 32'h0000028C;
      5'd21:   atanTurn = 32'h00000146;
      5'd22:   atanTurn = 32'h000000A3;
      5'd23:   atanTurn = 32'h00000051;
      default: atanTurn = 32'h00000000;
    endcase
  endfunction

  // Rescale the 2^32-per-turn table entry to the phase resolution, rounding.
  function automatic logic signed [ZW-1:0] atanStep(input logic [CW-1:0] i);
    atanStep = ZW'(({1'b0, atanTurn(i)} + (33'd1 << (31 - DEG_WD))) >> (32 - DEG_WD));
  endfunction

  // Drop the guard bits with round-half-up, then clamp to +/-1.0.
  function automatic logic signed [OUT_WD-1:0] roundSat(input logic signed [W-1:0] v);
    logic signed [W:0] t;
    t = ($signed({v[W-1], v}) + RND_HALF) >>> GUARD;
    if (t > POS_LIM)      roundSat = OUT_WD'(POS_LIM);
    else if (t < NEG_LIM) roundSat = OUT_WD'(NEG_LIM);
    else                  roundSat = OUT_WD'(t);
  endfunction

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [W-1:0]      x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]     z_q, z_d;
  logic [1:0]               quad_q, quad_d;
  logic                     outVld_q, outVld_d;
  logic signed [OUT_WD-1:0] sinVal_q, sinVal_d, cosVal_q, cosVal_d;
  logic                     busy_q;

  logic                     accept;
  logic                     dPos;
  logic signed [W-1:0]      xNext, yNext;
  logic signed [ZW-1:0]     zNext;
  logic signed [OUT_WD-1:0] rx, ry;

  assign in_rdy = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_rdy));
  assign accept = in_vld & in_rdy;

  // One micro-rotation: steer toward zero residual angle.
  always_comb begin
    dPos  = ~z_q[ZW-1];
    xNext = dPos ? (x_q - (y_q >>> cnt_q)) : (x_q + (y_q >>> cnt_q));
    yNext = dPos ? (y_q + (x_q >>> cnt_q)) : (y_q - (x_q >>> cnt_q));
    zNext = dPos ? (z_q - atanStep(cnt_q)) : (z_q + atanStep(cnt_q));
    rx    = roundSat(xNext);
    ry    = roundSat(yNext);
  end

  // Next-state logic. A new theta may be loaded from IDLE or, back-to-back,
  // from DONE in the same cycle the pending result is taken.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    quad_d   = quad_q;
    outVld_d = outVld_q;
    sinVal_d = sinVal_q;
    cosVal_d = cosVal_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        x_d   = xNext;
        y_d   = yNext;
        z_d   = zNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d  = DONE;
          outVld_d = 1'b1;
          // Negation after saturation keeps +/-1.0 symmetric.
          case (quad_q)
            2'd0:    begin sinVal_d = ry;  cosVal_d = rx;  end
            2'd1:    begin sinVal_d = rx;  cosVal_d = -ry; end
            2'd2:    begin sinVal_d = -ry; cosVal_d = -rx; end
            default: begin sinVal_d = -rx; cosVal_d = ry;  end
          endcase
        end
      end
      DONE: begin
        if (out_rdy) begin
          outVld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      quad_d  = theta[DEG_WD-1:DEG_WD-2];
      z_d     = $signed({3'b000, theta[DEG_WD-3:0]});
      x_d     = X_INIT;
      y_d     = '0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  // State registers; reset discards any in-flight or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      quad_q   <= '0;
      outVld_q <= 1'b0;
      sinVal_q <= '0;
      cosVal_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      quad_q   <= quad_d;
      outVld_q <= outVld_d;
      sinVal_q <= sinVal_d;
      cosVal_q <= cosVal_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign out_vld = outVld_q;
  assign sin_val = sinVal_q;
  assign cos_val = cosVal_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ip_sincos_cordic.sv
// ---------------------------------------------------------------------------
// tb_ip_sincos_cordic
//   Directed bench for the CORDIC sine/cosine generator with default
//   parameters: reset state, cardinal and oblique angles, backpressure,
//   back-to-back streaming, reset in RUN and DONE, and a coarse phase sweep
//   against a real-valued sine/cosine reference.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ip_sincos_cordic;

  localparam int DEG_WD = 17;
  localparam int OUT_WD = 14;
  localparam int ITER   = 16;
  localparam int GUARD  = 4;
  localparam int ONE    = 4096;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_vld;
  logic                     in_rdy;
  logic [DEG_WD-1:0]        theta;
  logic                     out_vld;
  logic                     out_rdy;
  logic signed [OUT_WD-1:0] sin_val;
  logic signed [OUT_WD-1:0] cos_val;
  logic                     busy;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int accCycle;
  int resCycle;
  int resSin;
  int resCos;

  ip_sincos_cordic #(
    .DEG_WD(DEG_WD),
    .OUT_WD(OUT_WD),
    .ITER  (ITER),
    .GUARD (GUARD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .theta  (theta),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .sin_val(sin_val),
    .cos_val(cos_val),
    .busy   (busy)
  );

  // 100 MHz clock plus a free-running edge counter for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop in case a handshake never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: tolerance 0 means exact match.
  task automatic checkOutput(input string tag, input int obs, input int exp, input int tol);
    int diff;
    total++;
    diff = (obs > exp) ? obs - exp : exp - obs;
    if (diff > tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Real-valued reference scaled to the output format.
  function automatic int refVal(input int th, input bit wantSin);
    real a;
    real v;
    a = 2.0 * 3.14159265358979 * th / 131072.0;
    v = (wantSin ? $sin(a) : $cos(a)) * ONE;
    refVal = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Called and returns just after a negedge. Offers theta until accepted.
  task automatic applyStimulus(input int th);
    int waitCnt;
    theta  = DEG_WD'(th);
    in_vld = 1'b1;
    #1;
    waitCnt = 0;
    while (!in_rdy && waitCnt < 100) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (!in_rdy) checkOutput("acceptTimeout", 0, 1, 0);
    @(negedge clk);
    in_vld   = 1'b0;
    accCycle = cycle;
    #1;
  endtask

  // Waits (bounded) for out_vld and captures the result.
  task automatic waitResult();
    int waitCnt;
    waitCnt = 0;
    while (!out_vld && waitCnt < 100) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (!out_vld) checkOutput("resultTimeout", 0, 1, 0);
    resCycle = cycle;
    resSin   = int'(sin_val);
    resCos   = int'(cos_val);
  endtask

  // Streams thetas with in_vld/out_rdy held high and checks order and period.
  task automatic runStream(input int n, input bit randomMode);
    int th[$];
    int prevAcc;
    for (int k = 0; k < n; k++)
      th.push_back(randomMode ? int'($urandom_range(0, 2 ** DEG_WD - 1)) : k * 512);
    out_rdy = 1'b1;
    applyStimulus(th[0]);
    prevAcc = accCycle;
    for (int k = 1; k <= n; k++) begin
      waitResult();
      checkOutput("streamSin", resSin, refVal(th[k-1], 1'b1), 2);
      checkOutput("streamCos", resCos, refVal(th[k-1], 1'b0), 2);
      checkOutput("streamSinRange", (resSin > ONE || resSin < -ONE) ? 1 : 0, 0, 0);
      checkOutput("streamCosRange", (resCos > ONE || resCos < -ONE) ? 1 : 0, 0, 0);
      if (k < n) begin
        applyStimulus(th[k]);
        checkOutput("streamPeriod", accCycle - prevAcc, ITER + 1, 0);
        prevAcc = accCycle;
      end
    end
  endtask

  typedef struct {
    int th;
    int s;
    int c;
    int tol;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst     = 1'b1;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    theta   = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstInRdy", int'(in_rdy), 0, 0);
    checkOutput("rstOutVld", int'(out_vld), 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("idleInRdy", int'(in_rdy), 1, 0);
    checkOutput("idleBusy", int'(busy), 0, 0);
    checkOutput("idleSin", int'(sin_val), 0, 0);
    checkOutput("idleCos", int'(cos_val), 0, 0);

    // First transaction: busy while running, latency from accept edge.
    applyStimulus(0);
    checkOutput("runBusy", int'(busy), 1, 0);
    checkOutput("runInRdy", int'(in_rdy), 0, 0);
    waitResult();
    checkOutput("latency", resCycle - accCycle, ITER, 0);
    checkOutput("zeroSin", resSin, 0, 1);
    checkOutput("zeroCos", resCos, ONE, 1);

    // Hand-computed directed vectors.
    vecs.push_back('{32'h08000,  4096,     0, 1});
    vecs.push_back('{32'h10000,     0, -4096, 1});
    vecs.push_back('{32'h18000, -4096,     0, 1});
    vecs.push_back('{32'h04000,  2896,  2896, 2});
    vecs.push_back('{32'h0C000,  2896, -2896, 2});
    vecs.push_back('{32'h14000, -2896, -2896, 2});
    vecs.push_back('{32'h1C000, -2896,  2896, 2});
    vecs.push_back('{32'h02AAB,  2048,  3547, 2});
    vecs.push_back('{32'h0AAAB,  3547, -2048, 2});
    vecs.push_back('{32'h1FFFF,     0,  4096, 2});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].th);
      waitResult();
      checkOutput("vecSin", resSin, vecs[i].s, vecs[i].tol);
      checkOutput("vecCos", resCos, vecs[i].c, vecs[i].tol);
    end

    // Backpressure: result holds for 5 cycles, then same-edge reload.
    @(negedge clk);
    #1;
    out_rdy = 1'b0;
    applyStimulus(32'h04000);
    waitResult();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput("bpOutVld", int'(out_vld), 1, 0);
      checkOutput("bpInRdy", int'(in_rdy), 0, 0);
      checkOutput("bpSin", int'(sin_val), 2896, 2);
      checkOutput("bpCos", int'(cos_val), 2896, 2);
    end
    out_rdy = 1'b1;
    applyStimulus(32'h08000);
    checkOutput("bpAcceptEdge", accCycle - resCycle, 6, 0);
    checkOutput("bpVldCleared", int'(out_vld), 0, 0);
    waitResult();
    checkOutput("bpLatency", resCycle - accCycle, ITER, 0);
    checkOutput("bpSin2", resSin, 4096, 1);
    checkOutput("bpCos2", resCos, 0, 1);

    // Back-to-back with random phases.
    @(negedge clk);
    #1;
    runStream(8, 1'b1);

    // Reset during RUN.
    @(negedge clk);
    #1;
    out_rdy = 1'b1;
    applyStimulus(32'h0C000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstRunInRdy", int'(in_rdy), 0, 0);
    @(negedge clk);
    #1;
    checkOutput("rstRunOutVld", int'(out_vld), 0, 0);
    checkOutput("rstRunSin", int'(sin_val), 0, 0);
    checkOutput("rstRunCos", int'(cos_val), 0, 0);
    checkOutput("rstRunBusy", int'(busy), 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("rstRunInRdyAfter", int'(in_rdy), 1, 0);

    // Reset in DONE with a pending result.
    out_rdy = 1'b0;
    applyStimulus(32'h14000);
    waitResult();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rstDoneOutVld", int'(out_vld), 0, 0);
    checkOutput("rstDoneSin", int'(sin_val), 0, 0);
    checkOutput("rstDoneCos", int'(cos_val), 0, 0);
    checkOutput("rstDoneBusy", int'(busy), 0, 0);
    rst = 1'b0;
    out_rdy = 1'b1;
    #1;
    checkOutput("rstDoneInRdyAfter", int'(in_rdy), 1, 0);
    applyStimulus(32'h02AAB);
    waitResult();
    checkOutput("freshSin", resSin, 2048, 2);
    checkOutput("freshCos", resCos, 3547, 2);

    // Coarse phase sweep over the full circle.
    @(negedge clk);
    #1;
    runStream(256, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
